// File: rtl/word_byte_serializer_if.sv
// Handshake bundle between a 32-bit word producer and a byte-stream consumer.
// The serializer takes the slave modport; whoever feeds it takes the master modport.
interface word_byte_serializer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_idx, out_last, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_idx, out_last, busy
  );
endinterface

// File: rtl/word_byte_serializer.sv
// Serializes 32-bit words into a byte stream, one byte per cycle.
// A one-word pending buffer lets back-to-back words flow without a bubble.
module word_byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  word_byte_serializer_if.slave         bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] pend_q, pend_d;
  logic        pendV_q, pendV_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        inXfer;
  logic        outXfer;
  logic [1:0]  byteSel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      pend_q  <= '0;
      pendV_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      pendV_q <= pendV_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inXfer  = bus.in_valid && !pendV_q;
  assign outXfer = (state_q == SEND) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    pendV_d = pendV_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (inXfer) begin
          cur_d   = bus.in_data;
          cnt_d   = 2'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (outXfer && cnt_q == 2'd3) begin
          // Word done: the pending word wins; otherwise a fresh word goes straight to cur.
          if (pendV_q) begin
            cur_d   = pend_q;
            pendV_d = 1'b0;
            cnt_d   = 2'd0;
          end else if (inXfer) begin
            cur_d = bus.in_data;
            cnt_d = 2'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (outXfer) begin
            cnt_d = cnt_q + 2'd1;
          end
          if (inXfer) begin
            pend_d  = bus.in_data;
            pendV_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byteSel = MSB_FIRST ? (2'd3 - cnt_q) : cnt_q;

  assign bus.in_ready  = !pendV_q;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = cur_q[{byteSel, 3'b000} +: 8];
  assign bus.out_idx   = cnt_q;
  assign bus.out_last  = (state_q == SEND) && (cnt_q == 2'd3);
  assign bus.busy      = (state_q == SEND) || pendV_q;

endmodule

// File: tb/tb_word_byte_serializer.sv
// Self-checking bench: two serializers (MSB-first and LSB-first) driven by identical stimulus,
// checked with a constant vector table, hand-written corner sequences and a random scoreboard.
module tb_word_byte_serializer;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic [31:0] inData;
  logic        outReady;

  int testsRun  = 0;
  int failCount = 0;

  word_byte_serializer_if busM ();
  word_byte_serializer_if busL ();

  assign busM.in_data   = inData;
  assign busM.in_valid  = inValid;
  assign busM.out_ready = outReady;
  assign busL.in_data   = inData;
  assign busL.in_valid  = inValid;
  assign busL.out_ready = outReady;

  word_byte_serializer #(.MSB_FIRST(1'b1)) dutM (.clk(clk), .reset(reset), .bus(busM));
  word_byte_serializer #(.MSB_FIRST(1'b0)) dutL (.clk(clk), .reset(reset), .bus(busL));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  msbBytes [4];
    logic [7:0]  lsbBytes [4];
  } vector_t;

  vector_t vectors [4];

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    inValid  = v;
    inData   = d;
    outReady = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkIdleM(input string name);
    checkOutput({name, " out_valid"}, {31'b0, busM.out_valid}, 32'd0);
    checkOutput({name, " busy"},      {31'b0, busM.busy},      32'd0);
    checkOutput({name, " in_ready"},  {31'b0, busM.in_ready},  32'd1);
  endtask

  // Reference model: expected byte queues per DUT, built from each accepted word.
  logic [7:0] qM[$];
  logic [7:0] qL[$];
  int         emitted;

  task automatic modelPush(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) qM.push_back(8'((w >> (8 * b)) & 32'hff));
    for (int b = 0; b < 4; b++)  qL.push_back(8'((w >> (8 * b)) & 32'hff));
  endtask

  initial begin
    logic [7:0] bbExp [8];
    logic [7:0] bpExp [12];
    logic       bpReady [12];
    int         accepted;
    int         cycles;
    logic       v, r, inX, outX, expValid, expInReady;
    logic [31:0] d;

    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);

    vectors[0] = '{32'hfff0ff0f, '{8'hff, 8'hf0, 8'hff, 8'h0f}, '{8'h0f, 8'hff, 8'hf0, 8'hff}};
    vectors[1] = '{32'h12345678, '{8'h12, 8'h34, 8'h56, 8'h78}, '{8'h78, 8'h56, 8'h34, 8'h12}};
    vectors[2] = '{32'hAABBCCDD, '{8'hAA, 8'hBB, 8'hCC, 8'hDD}, '{8'hDD, 8'hCC, 8'hBB, 8'hAA}};
    vectors[3] = '{32'h00000001, '{8'h00, 8'h00, 8'h00, 8'h01}, '{8'h01, 8'h00, 8'h00, 8'h00}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    checkIdleM("reset");
    checkOutput("reset out_data", {24'b0, busM.out_data}, 32'h00);
    checkOutput("reset out_idx",  {30'b0, busM.out_idx},  32'd0);
    checkOutput("reset out_last", {31'b0, busM.out_last}, 32'd0);
    checkOutput("reset busy LSB", {31'b0, busL.busy},     32'd0);

    // Single words with out_ready held high: 4 bytes starting one cycle after accept.
    for (int i = 0; i < 4; i++) begin
      checkOutput("pre-accept out_valid", {31'b0, busM.out_valid}, 32'd0);
      applyStimulus(1'b1, vectors[i].word, 1'b1);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
        checkOutput("vec out_valid",     {31'b0, busM.out_valid}, 32'd1);
        checkOutput("vec MSB out_data",  {24'b0, busM.out_data},  {24'b0, vectors[i].msbBytes[k]});
        checkOutput("vec LSB out_data",  {24'b0, busL.out_data},  {24'b0, vectors[i].lsbBytes[k]});
        checkOutput("vec out_idx",       {30'b0, busM.out_idx},   32'(k));
        checkOutput("vec out_last",      {31'b0, busM.out_last},  {31'b0, k == 3});
        @(posedge clk);
        @(negedge clk);
      end
      checkIdleM("vec done");
    end

    // Back-to-back words: eight contiguous bytes with no gap.
    bbExp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(1'b1, 32'hAABBCCDD, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("b2b out_valid", {31'b0, busM.out_valid}, 32'd1);
      checkOutput("b2b out_data",  {24'b0, busM.out_data},  {24'b0, bbExp[k]});
      checkOutput("b2b out_last",  {31'b0, busM.out_last},  {31'b0, (k == 3) || (k == 7)});
      if (k == 0) applyStimulus(1'b1, 32'h11223344, 1'b1);
      else        applyStimulus(1'b0, 32'h0, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    checkIdleM("b2b done");

    // Backpressure: two words held, third stalls until the second moves into cur.
    applyStimulus(1'b1, 32'hAABBCCDD, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp in_ready word2", {31'b0, busM.in_ready}, 32'd1);
    applyStimulus(1'b1, 32'h11223344, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 32'h55667788, 1'b0);
    for (int s = 0; s < 4; s++) begin
      checkOutput("bp stall in_ready", {31'b0, busM.in_ready}, 32'd0);
      checkOutput("bp stall out_data", {24'b0, busM.out_data}, 32'hAA);
      checkOutput("bp stall out_idx",  {30'b0, busM.out_idx},  32'd0);
      checkOutput("bp stall busy",     {31'b0, busM.busy},     32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bpExp   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88};
    bpReady = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 12; c++) begin
      checkOutput("bp out_valid", {31'b0, busM.out_valid}, 32'd1);
      checkOutput("bp out_data",  {24'b0, busM.out_data},  {24'b0, bpExp[c]});
      checkOutput("bp in_ready",  {31'b0, busM.in_ready},  {31'b0, bpReady[c]});
      applyStimulus(c <= 4, 32'h55667788, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkIdleM("bp done");

    // Reset mid-word with a pending word; reset beats a simultaneous handshake.
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 32'hCAFEBABE, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst mid out_data", {24'b0, busM.out_data}, 32'hAD);
    checkOutput("rst mid busy",     {31'b0, busM.busy},     32'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 32'hBAD0BAD0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkIdleM("rst mid after");
    checkOutput("rst mid out_data 0", {24'b0, busM.out_data}, 32'h00);
    applyStimulus(1'b1, 32'h01020304, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("rst resend out_valid", {31'b0, busM.out_valid}, 32'd1);
      checkOutput("rst resend out_data",  {24'b0, busM.out_data},  32'(k + 1));
      @(posedge clk);
      @(negedge clk);
    end
    checkIdleM("rst resend done");

    // Random traffic against the queue-based scoreboard.
    doReset();
    qM.delete();
    qL.delete();
    emitted  = 0;
    accepted = 0;
    cycles   = 0;
    while ((accepted < 200 || qM.size() != 0) && cycles < 6000) begin
      @(negedge clk);
      expValid   = (qM.size() != 0);
      expInReady = ((qM.size() + 3) / 4) < 2;
      checkOutput("rnd out_valid M", {31'b0, busM.out_valid}, {31'b0, expValid});
      checkOutput("rnd out_valid L", {31'b0, busL.out_valid}, {31'b0, expValid});
      checkOutput("rnd in_ready",    {31'b0, busM.in_ready},  {31'b0, expInReady});
      checkOutput("rnd busy",        {31'b0, busM.busy},      {31'b0, expValid});
      checkOutput("rnd out_last",    {31'b0, busM.out_last},  {31'b0, expValid && (emitted % 4 == 3)});
      if (expValid) begin
        checkOutput("rnd out_data M", {24'b0, busM.out_data}, {24'b0, qM[0]});
        checkOutput("rnd out_data L", {24'b0, busL.out_data}, {24'b0, qL[0]});
        checkOutput("rnd out_idx",    {30'b0, busM.out_idx},  32'(emitted % 4));
      end
      v = (accepted < 200) && ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 7);
      d = $urandom;
      applyStimulus(v, d, r);
      inX  = v && expInReady;
      outX = expValid && r;
      @(posedge clk);
      if (outX) begin
        void'(qM.pop_front());
        void'(qL.pop_front());
        emitted++;
      end
      if (inX) begin
        modelPush(d);
        accepted++;
      end
      cycles++;
    end
    checkOutput("rnd words accepted", 32'(accepted), 32'd200);
    checkOutput("rnd queue drained",  32'(qM.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
